// File: rtl/sonar_medida_uc_if.sv
// Signal bundle between the measurement sequencer and its surroundings
// (request, echo/counter status in; trigger, counter restart and result out).
interface sonar_medida_uc_if;
  logic        medir;
  logic        echo;
  logic        cm_pronto;
  logic        cm_fim;
  logic [11:0] cm_digitos;
  logic        trigger;
  logic        cm_zera;
  logic [11:0] distancia;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  modport master (
    output medir, echo, cm_pronto, cm_fim, cm_digitos,
    input  trigger, cm_zera, distancia, pronto, erro, db_estado
  );

  modport slave (
    input  medir, echo, cm_pronto, cm_fim, cm_digitos,
    output trigger, cm_zera, distancia, pronto, erro, db_estado
  );
endinterface

// File: rtl/sonar_medida_uc.sv
// Ultrasonic measurement sequencer: trigger, echo timeout, result latch.
// Optional periodic self-trigger enabled by defining AUTO_MEDIDA_EN.
module sonar_medida_uc #(
  parameter int T_TRIG    = 500,
  parameter int T_TIMEOUT = 1_500_000,
  parameter int T_PERIODO = 12_500_000
) (
  input  logic               clock,
  input  logic               reset,
  sonar_medida_uc_if.slave   bus
);

  typedef enum logic [3:0] {
    st_inicial       = 4'h0,
    st_preparacao    = 4'h1,
    st_envia_trigger = 4'h2,
    st_espera_echo   = 4'h3,
    st_medida        = 4'h4,
    st_armazena      = 4'h5,
    st_final         = 4'h6,
    st_erro          = 4'hF
  } estado_t;

  localparam int TRIG_W = (T_TRIG > 1) ? $clog2(T_TRIG) : 1;
  localparam int TO_W   = (T_TIMEOUT > 1) ? $clog2(T_TIMEOUT) : 1;
  localparam logic [TRIG_W-1:0] TRIG_FIM = TRIG_W'(T_TRIG - 1);
  localparam logic [TO_W-1:0]   TO_FIM   = TO_W'(T_TIMEOUT - 1);

  estado_t           estado, prox;
  logic [TRIG_W-1:0] cnt_trig;
  logic [TO_W-1:0]   cnt_to;
  logic              auto_req;
  logic              inicia;
  logic              trigger_r, cm_zera_r, pronto_r, erro_r;
  logic [11:0]       distancia_r;

  always_comb begin
    prox = estado;
    case (estado)
      st_inicial:       if (bus.medir || auto_req) prox = st_preparacao;
      st_preparacao:    prox = st_envia_trigger;
      st_envia_trigger: if (cnt_trig == TRIG_FIM) prox = st_espera_echo;
      st_espera_echo: begin
        if (cnt_to == TO_FIM)  prox = st_erro;
        else if (bus.echo)     prox = st_medida;
      end
      // timeout beats overflow, overflow beats a valid result
      st_medida: begin
        if (cnt_to == TO_FIM)     prox = st_erro;
        else if (bus.cm_fim)      prox = st_erro;
        else if (bus.cm_pronto)   prox = st_armazena;
      end
      st_armazena:      prox = st_final;
      st_final:         prox = st_inicial;
      st_erro:          prox = st_inicial;
      default:          prox = st_inicial;
    endcase
  end

  assign inicia = (estado == st_inicial) && (prox == st_preparacao);

  always_ff @(posedge clock) begin
    if (reset) estado <= st_inicial;
    else       estado <= prox;
  end

  // Both counters saturate at their terminal value until the next preparacao.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_trig <= '0;
      cnt_to   <= '0;
    end else if (estado == st_preparacao) begin
      cnt_trig <= '0;
      cnt_to   <= '0;
    end else begin
      if (estado == st_envia_trigger && cnt_trig != TRIG_FIM)
        cnt_trig <= cnt_trig + 1'b1;
      if ((estado == st_espera_echo || estado == st_medida) && cnt_to != TO_FIM)
        cnt_to <= cnt_to + 1'b1;
    end
  end

  // Outputs registered from the next state so they align with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      trigger_r   <= 1'b0;
      cm_zera_r   <= 1'b0;
      pronto_r    <= 1'b0;
      erro_r      <= 1'b0;
      distancia_r <= '0;
    end else begin
      trigger_r <= (prox == st_envia_trigger);
      cm_zera_r <= (prox == st_preparacao);
      pronto_r  <= (prox == st_final);
      if (estado == st_armazena) distancia_r <= bus.cm_digitos;
      if (prox == st_preparacao)  erro_r <= 1'b0;
      else if (prox == st_erro)   erro_r <= 1'b1;
    end
  end

`ifdef AUTO_MEDIDA_EN
  localparam int PER_W = (T_PERIODO > 1) ? $clog2(T_PERIODO) : 1;
  localparam logic [PER_W-1:0] PER_FIM = PER_W'(T_PERIODO - 1);

  logic [PER_W-1:0] cnt_per;
  logic             pendente;

  // A wrap wins over consumption so a request is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_per  <= '0;
      pendente <= 1'b0;
    end else if (cnt_per == PER_FIM) begin
      cnt_per  <= '0;
      pendente <= 1'b1;
    end else begin
      cnt_per <= cnt_per + 1'b1;
      if (inicia) pendente <= 1'b0;
    end
  end

  assign auto_req = pendente;
`else
  assign auto_req = 1'b0 & (T_PERIODO == 0);
`endif

  assign bus.trigger   = trigger_r;
  assign bus.cm_zera   = cm_zera_r;
  assign bus.pronto    = pronto_r;
  assign bus.erro      = erro_r;
  assign bus.distancia = distancia_r;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_sonar_medida_uc.sv
// Scoreboard bench for sonar_medida_uc: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sonar_medida_uc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sonar_medida_uc_if bus ();

  sonar_medida_uc #(
    .T_TRIG    (5),
    .T_TIMEOUT (200),
    .T_PERIODO (1000)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // kind: 0 zera (v1=db_estado, v2=cycles since previous zera)
  //       1 trigger fall (v1=high length)
  //       2 pronto (v1=distancia, v2=cycles since cm_pronto)
  //       3 erro rise (v1={db_estado,distancia}, v2=cycles since trigger fall)
  typedef struct {
    int kind;
    int v1;
    int v2;
    bit chk2;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_err    = 0;
  bit  mon_en   = 1'b0;

  int  trig_len = 0, since_trig = 0, since_pr = 0, since_zera = 0;
  logic prev_trig = 1'b0, prev_erro = 1'b0;

  function automatic string ev_nome(input int k);
    case (k)
      0: return "cm_zera";
      1: return "trigger_len";
      2: return "pronto";
      default: return "erro";
    endcase
  endfunction

  function automatic ev_t mk(input int k, input int a, input int b, input bit c);
    ev_t e;
    e.kind = k; e.v1 = a; e.v2 = b; e.chk2 = c;
    return e;
  endfunction

  task automatic post(input int k, input int a, input int b);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: got v1='h%0h v2=%0d, required no event", ev_nome(k), a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.v1 != a || (e.chk2 && e.v2 != b)) begin
        n_err++;
        $display("FAIL ev_%s: got %s v1='h%0h v2=%0d, required %s v1='h%0h v2=%0d",
                 ev_nome(e.kind), ev_nome(k), a, b, ev_nome(e.kind), e.v1, e.v2);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      since_trig++;
      since_pr++;
      since_zera++;
      if (bus.cm_zera) begin
        post(0, int'(bus.db_estado), since_zera);
        since_zera = 0;
      end
      if (bus.trigger) trig_len++;
      if (prev_trig && !bus.trigger) begin
        post(1, trig_len, 0);
        trig_len   = 0;
        since_trig = 0;
      end
      if (bus.cm_pronto) since_pr = 0;
      if (bus.pronto) post(2, int'(bus.distancia), since_pr);
      if (bus.erro && !prev_erro) post(3, int'({bus.db_estado, bus.distancia}), since_trig);
    end
    prev_trig = bus.trigger;
    prev_erro = bus.erro;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", nm, act, req);
    end
  endtask

  task automatic wait_trig(input logic want);
    int n = 0;
    while (bus.trigger !== want && n < 2000) begin
      tick(1);
      n++;
    end
    if (bus.trigger !== want) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_trigger: got %b after %0d cycles, required %b", bus.trigger, n, want);
    end
  endtask

  task automatic pulse_medir();
    bus.medir = 1'b1;
    tick(1);
    bus.medir = 1'b0;
  endtask

  task automatic std_start();
    exp_q.push_back(mk(0, 1, 0, 1'b0));
    exp_q.push_back(mk(1, 5, 0, 1'b0));
  endtask

  initial begin
    bus.medir      = 1'b0;
    bus.echo       = 1'b0;
    bus.cm_pronto  = 1'b0;
    bus.cm_fim     = 1'b0;
    bus.cm_digitos = '0;
    tick(3);
    chk("rst_trigger",   int'(bus.trigger),   0);
    chk("rst_cm_zera",   int'(bus.cm_zera),   0);
    chk("rst_distancia", int'(bus.distancia), 0);
    chk("rst_pronto",    int'(bus.pronto),    0);
    chk("rst_erro",      int'(bus.erro),      0);
    chk("rst_db_estado", int'(bus.db_estado), 0);

`ifdef AUTO_MEDIDA_EN
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(0, 1, 1000, i != 0));
      exp_q.push_back(mk(1, 5, 0, 1'b0));
      exp_q.push_back(mk(3, 'hF000, 200, 1'b1));
    end
    mon_en = 1'b1;
    rst = 1'b0;
    tick(3300);
`else
    mon_en = 1'b1;
    rst = 1'b0;
    tick(2);

    // normal measurement
    std_start();
    exp_q.push_back(mk(2, 'h123, 2, 1'b1));
    pulse_medir();
    wait_trig(1'b1);
    wait_trig(1'b0);
    tick(10);
    bus.echo = 1'b1;
    tick(3);
    bus.cm_digitos = 12'h123;
    bus.cm_pronto  = 1'b1;
    tick(1);
    bus.cm_pronto = 1'b0;
    bus.echo      = 1'b0;
    tick(5);
    chk("norm_erro",      int'(bus.erro),      0);
    chk("norm_distancia", int'(bus.distancia), 'h123);

    // no echo: timeout exactly 200 cycles after trigger end
    std_start();
    exp_q.push_back(mk(3, 'hF123, 200, 1'b1));
    pulse_medir();
    wait_trig(1'b1);
    wait_trig(1'b0);
    tick(210);

    // overflow and pronto together
    std_start();
    exp_q.push_back(mk(3, 'hF123, 0, 1'b0));
    pulse_medir();
    wait_trig(1'b1);
    wait_trig(1'b0);
    tick(2);
    bus.echo = 1'b1;
    tick(3);
    bus.cm_digitos = 12'h999;
    bus.cm_fim     = 1'b1;
    bus.cm_pronto  = 1'b1;
    tick(1);
    bus.cm_fim    = 1'b0;
    bus.cm_pronto = 1'b0;
    bus.echo      = 1'b0;
    tick(5);
    chk("ovf_distancia", int'(bus.distancia), 'h123);

    // busy request ignored, then recovery
    std_start();
    exp_q.push_back(mk(2, 'h045, 2, 1'b1));
    pulse_medir();
    chk("rec_erro_prep",  int'(bus.erro),      0);
    chk("rec_estado_prep", int'(bus.db_estado), 1);
    wait_trig(1'b1);
    wait_trig(1'b0);
    tick(3);
    pulse_medir();
    tick(5);
    bus.echo = 1'b1;
    tick(2);
    bus.cm_digitos = 12'h045;
    bus.cm_pronto  = 1'b1;
    tick(1);
    bus.cm_pronto = 1'b0;
    bus.echo      = 1'b0;
    tick(20);
    chk("rec_distancia", int'(bus.distancia), 'h045);

    // reset during the 3rd trigger cycle
    exp_q.push_back(mk(0, 1, 0, 1'b0));
    exp_q.push_back(mk(1, 3, 0, 1'b0));
    pulse_medir();
    wait_trig(1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstmid_trigger",   int'(bus.trigger),   0);
    chk("rstmid_db_estado", int'(bus.db_estado), 0);
    chk("rstmid_distancia", int'(bus.distancia), 0);
    tick(10);
    chk("rstmid_pronto",    int'(bus.pronto),    0);
`endif

    tick(5);
    chk("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sonar_medida_uc.md
# sonar_medida_uc

Measurement sequencer for the ultrasonic distance path. It drives the sensor trigger and owns the restart of the echo-width-to-centimetre counter (the 3-digit BCD `cm` counter with `fim`/`pronto`). It also enforces an echo timeout and latches each valid 3-digit BCD result for the display and serial layers. The block sits between the top-level `medir` request and the counter, and is the only agent that starts and abandons a measurement.

## Interface
Parameters:
- `T_TRIG`, 500 — trigger high time in clocks (10 µs at 50 MHz).
- `T_TIMEOUT`, 1_500_000 — maximum clocks from trigger end to counter `pronto` (30 ms).
- `T_PERIODO`, 12_500_000 — auto-measurement period in clocks; used only with `AUTO_MEDIDA_EN`.

Ports:
- `clock` in 1 — single system clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high; returns every register to its reset value on the next edge.
- `medir` in 1 — measurement request, level or pulse; sampled only in `inicial`.
- `echo` in 1 — synchronized sensor echo; monitored only, the counter receives it directly.
- `cm_pronto` in 1 — counter finished after the echo falling edge.
- `cm_fim` in 1 — counter saturated (999 cm).
- `cm_digitos` in 12 — counter BCD digits {d2,d1,d0}.
- `trigger` out 1 — sensor trigger.
- `cm_zera` out 1 — counter reset, one-cycle pulse.
- `distancia` out 12 — last valid BCD result, registered.
- `pronto` out 1 — one-cycle pulse when `distancia` is updated.
- `erro` out 1 — sticky timeout/overflow flag.
- `db_estado` out 4 — current state encoding.

## Operation
The block is a Moore FSM with a registered state and registered outputs.
- `inicial` (0x0): idle. Leaves to `preparacao` when `medir`=1 (or the auto request is pending).
- `preparacao` (0x1): one cycle. `cm_zera`=1; clears the trigger and timeout counters; clears `erro`. Next state is `envia_trigger`.
- `envia_trigger` (0x2): `trigger`=1 for exactly `T_TRIG` cycles. Next state is `espera_echo`.
- `espera_echo` (0x3): waits for `echo`=1, then goes to `medida`. The timeout counter runs.
- `medida` (0x4): waits for `cm_pronto`=1, then goes to `armazena`. The timeout counter keeps running and is not cleared.
- `armazena` (0x5): one cycle. `distancia` <= `cm_digitos`. Next state is `final`.
- `final` (0x6): one cycle. `pronto`=1. Next state is `inicial`.
- `erro_st` (0xF): one cycle. Sets `erro`; `distancia` is unchanged. Next state is `inicial`.

Transition rules:
- Timeout: in `espera_echo` or `medida`, when the timeout counter reaches `T_TIMEOUT`-1, the FSM goes to `erro_st`. This has priority over `echo` and `cm_pronto` in the same cycle.
- Overflow: `cm_fim`=1 in `medida` goes to `erro_st`. This has priority over `cm_pronto`.
- `medir` outside `inicial` is ignored and is not queued.
- `db_estado` encodings are as listed; unused codes recover to `inicial`.

Counter sizing: trigger counter is $clog2(`T_TRIG`) bits; timeout counter is $clog2(`T_TIMEOUT`) bits. Neither counter wraps; each holds at its terminal value until cleared.

## Timing
- Reset values: state `inicial`, `trigger`=0, `cm_zera`=0, `distancia`=12'h000, `pronto`=0, `erro`=0, `db_estado`=0x0.
- `medir` sampled high at edge k puts the FSM in `preparacao` after edge k. `cm_zera` is high during cycle k+1.
- `trigger` rises after edge k+1 and is high for exactly `T_TRIG` cycles.
- Latency from the `cm_pronto` sampling edge to the `pronto` pulse is 2 cycles. `distancia` is valid in the same cycle as `pronto` and holds afterwards.
- `erro` rises on entry to `erro_st` and stays high until the next `preparacao`.
- `medir` held high continuously causes back-to-back measurements with one idle cycle in `inicial` between them.
- Reset mid-operation: `trigger` is low after the next edge; no `pronto` is produced; `distancia` returns to 0.

## Configuration
- `AUTO_MEDIDA_EN` defined:
  - A free-running counter of width $clog2(`T_PERIODO`) bits wraps every `T_PERIODO` clocks.
  - Each wrap sets a one-deep pending request. The request is consumed on the transition `inicial`->`preparacao`, from either source.
  - A wrap while busy sets the pending bit only once; further wraps while busy are dropped.
  - `reset` clears both the period counter and the pending bit.
- `AUTO_MEDIDA_EN` undefined: only `medir` starts a measurement. `T_PERIODO` is ignored and no period logic is synthesized.

## Test plan
All scenarios use `T_TRIG`=5 and `T_TIMEOUT`=200.
- Normal measurement: pulse `medir`, raise `echo` 10 cycles after trigger end, give `cm_pronto` with `cm_digitos`=12'h123. Expect `cm_zera` for 1 cycle, `trigger` high for exactly 5 cycles, `pronto` 2 cycles after `cm_pronto`, `distancia`=12'h123, `erro`=0.
- No echo: pulse `medir` and keep `echo`=0. Expect `erro`=1 exactly 200 cycles after trigger end, no `pronto`, `distancia` still 12'h123, `db_estado` passing through 0xF.
- Overflow: assert `cm_fim`=1 and `cm_pronto`=1 in the same cycle during `medida`. Expect `erro`=1, no `pronto`, `distancia` unchanged.
- Busy request and recovery: pulse `medir` during `espera_echo`; expect no second measurement. Then complete a valid measurement with 12'h045 and expect `erro` cleared at `preparacao` and `distancia`=12'h045.
- Reset mid-trigger: assert `reset` on the 3rd trigger cycle. Expect `trigger`=0 and `db_estado`=0x0 after that edge, `distancia`=12'h000.
- With `AUTO_MEDIDA_EN`, `T_PERIODO`=1000, and `medir`=0 throughout: expect `cm_zera` pulses exactly 1000 cycles apart.
